// File: rtl/mw_add_seq.sv
// rtl/mw_add_seq.sv - wide adder sequenced one WIDTH-bit slice per cycle
// through an external combinational slice adder on the add_* ports.
module mw_add_seq #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] op_a,
  input  logic [WIDTH*WORDS-1:0] op_b,
  input  logic                   cin_in,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] result,
  output logic                   cout_out,
  output logic                   ovf,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_s,
  input  logic                   add_cout
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic                        carry_q, carry_d;
  logic [WORDS-1:0][WIDTH-1:0] a_q, a_d;
  logic [WORDS-1:0][WIDTH-1:0] b_q, b_d;
  logic [WORDS-1:0][WIDTH-1:0] res_q, res_d;
  logic                        cout_q, cout_d;
  logic                        ovf_q, ovf_d;
  logic                        a_msb, b_msb;

  assign a_msb    = a_q[WORDS-1][WIDTH-1];
  assign b_msb    = b_q[WORDS-1][WIDTH-1];
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign cout_out = cout_q;
  assign ovf      = ovf_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin_in;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a        = a_q[idx_q];
        add_b        = b_q[idx_q];
        add_cin      = carry_q;
        res_d[idx_q] = add_s;
        carry_d      = add_cout;
        // Overflow is judged on the top slice only: operand signs vs. sum sign.
        if (idx_q == IDXW'(WORDS - 1)) begin
          cout_d  = add_cout;
          ovf_d   = (a_msb == b_msb) && (add_s[WIDTH-1] != a_msb);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
